// File: rtl/vc_mem_arb_2to1.sv
`timescale 1ns/1ps
// vc_mem_arb_2to1: round-robin 2:1 arbiter onto one val/rdy memory port.
// Requests pass through combinationally; a small id FIFO records grant order
// so in-order memory responses are steered back to the right requester.
// Optional: define VC_MEM_ARB_PERF_EN to add grant / full-stall counters.
module vc_mem_arb_2to1 #(
  parameter int p_req_msg_sz   = 67,
  parameter int p_resp_msg_sz  = 37,
  parameter int p_max_inflight = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [p_req_msg_sz-1:0]  req0_msg,
  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [p_req_msg_sz-1:0]  req1_msg,
  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [p_resp_msg_sz-1:0] resp0_msg,
  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [p_resp_msg_sz-1:0] resp1_msg,
  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [p_req_msg_sz-1:0]  memreq_msg,
  input  logic                     memresp_val,
  output logic                     memresp_rdy,
  input  logic [p_resp_msg_sz-1:0] memresp_msg
`ifdef VC_MEM_ARB_PERF_EN
  ,
  output logic [31:0]              perf_grant0,
  output logic [31:0]              perf_grant1,
  output logic [31:0]              perf_full_stall
`endif
);

  localparam int          PW       = $clog2(p_max_inflight);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(p_max_inflight);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic                      prio;
  logic [p_max_inflight-1:0] ids;
  logic [PW-1:0]             head, tail;
  logic [PW:0]               count;

  logic gnt_vld, gnt_id;
  logic full, empty, head_id;
  logic req_fire, resp_fire;

  // Grant: lone requester wins, a tie goes to the favoured one.
  always_comb begin
    gnt_vld = req0_val | req1_val;
    gnt_id  = (req0_val & req1_val) ? prio : req1_val;
  end

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign head_id = ids[head];

  // Request side: message follows the grant; a full tracker blocks everyone.
  assign memreq_val = gnt_vld & ~full;
  assign memreq_msg = (gnt_vld & gnt_id) ? req1_msg : req0_msg;
  assign req0_rdy   = gnt_vld & ~gnt_id & memreq_rdy & ~full;
  assign req1_rdy   = gnt_vld &  gnt_id & memreq_rdy & ~full;
  assign req_fire   = memreq_val & memreq_rdy;

  // Response side: only the requester at the head of the tracker may take it,
  // so a stalled head blocks responses for the other requester.
  assign memresp_rdy = ~empty & (head_id ? resp1_rdy : resp0_rdy);
  assign resp0_val   = memresp_val & ~empty & ~head_id;
  assign resp1_val   = memresp_val & ~empty &  head_id;
  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign resp_fire   = memresp_val & memresp_rdy;

  // Tracker FIFO and round-robin priority; pointers wrap on their own width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio  <= 1'b0;
      ids   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (req_fire) begin
        ids[tail] <= gnt_id;
        tail      <= tail + PTR_ONE;
        prio      <= ~gnt_id;
      end
      if (resp_fire) head <= head + PTR_ONE;
      case ({req_fire, resp_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef VC_MEM_ARB_PERF_EN
  // Free-running event counters; wrap at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_grant0     <= '0;
      perf_grant1     <= '0;
      perf_full_stall <= '0;
    end else begin
      if (req_fire & ~gnt_id)  perf_grant0     <= perf_grant0 + 32'd1;
      if (req_fire &  gnt_id)  perf_grant1     <= perf_grant1 + 32'd1;
      if (gnt_vld & full)      perf_full_stall <= perf_full_stall + 32'd1;
    end
  end
`endif

endmodule
